// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings and defaults for the data-memory arbiter.
// The latency-counter width covers MEM_LAT and STARVE_MAX up to 15.
package dmem_arbiter_pkg;

    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_MEM_LAT    = 2;
    localparam int DEF_STARVE_MAX = 4;
    localparam int CNT_W          = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef enum logic {
        CORE = 1'b0,
        LDR  = 1'b1
    } owner_t;

endpackage

// File: rtl/dmem_lat_counter.sv
// Access-latency down-counter: load arms it with MEM_LAT-1, and last flags
// the final cycle of the memory access.
module dmem_lat_counter
    import dmem_arbiter_pkg::*;
#(
    parameter int MEM_LAT = DEF_MEM_LAT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic last
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            cnt <= '0;
        else if (load)         cnt <= CNT_W'(MEM_LAT - 1);
        else if (cnt != '0)    cnt <= cnt - 1'b1;
    end

    assign last = (cnt == '0);

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single data-memory port between the core MEM stage and a
// loader/debug port; the loader wins after STARVE_MAX contended core grants.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int MEM_LAT    = DEF_MEM_LAT,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              core_rd,
    input  logic              core_wr,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_stall,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_ack,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t            state, state_nxt;
    owner_t            owner;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              we_q;
    logic [CNT_W-1:0]  starve_cnt;
    logic              core_req, grant_core, grant_ldr, lat_last;

    assign core_req   = core_rd | core_wr;
    assign grant_core = (state == IDLE) && core_req &&
                        !(ldr_req && (starve_cnt == CNT_W'(STARVE_MAX)));
    assign grant_ldr  = (state == IDLE) && ldr_req && !grant_core;

    dmem_lat_counter #(.MEM_LAT(MEM_LAT)) u_lat (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (grant_core | grant_ldr),
        .last  (lat_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        ldr_ack   = 1'b0;
        // The core sees its release only in the DONE cycle of its own access.
        core_stall = core_req;
        case (state)
            IDLE: begin
                if (grant_core || grant_ldr) state_nxt = ACCESS;
            end
            ACCESS: begin
                mem_en = 1'b1;
                mem_we = we_q;
                if (lat_last) state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
                if (owner == CORE) core_stall = 1'b0;
                else               ldr_ack    = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner      <= CORE;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            starve_cnt <= '0;
            core_rdata <= '0;
            ldr_rdata  <= '0;
        end else begin
            if (grant_core) begin
                owner   <= CORE;
                addr_q  <= core_addr;
                wdata_q <= core_wdata;
                we_q    <= core_wr;
                if (ldr_req && (starve_cnt != CNT_W'(STARVE_MAX)))
                    starve_cnt <= starve_cnt + 1'b1;
            end else if (grant_ldr) begin
                owner      <= LDR;
                addr_q     <= ldr_addr;
                wdata_q    <= ldr_wdata;
                we_q       <= ldr_we;
                starve_cnt <= '0;
            end
            if ((state == ACCESS) && lat_last) begin
                if (owner == CORE) core_rdata <= mem_rdata;
                else               ldr_rdata  <= mem_rdata;
            end
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus a random run checked
// against a transaction-timing model (grant time + fixed latency).
module tb_dmem_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int LAT  = 2;
    localparam int SMAX = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          core_rd, core_wr, ldr_req, ldr_we;
    logic [AW-1:0] core_addr, ldr_addr, mem_addr;
    logic [DW-1:0] core_wdata, ldr_wdata, core_rdata, ldr_rdata, mem_wdata, mem_rdata;
    logic          core_stall, ldr_ack, mem_en, mem_we;

    int total = 0;
    int bad   = 0;

    // Environment memory: combinational read, write at each edge of a write access.
    logic [31:0] mem [0:255];
    logic        pl_en = 1'b0;
    logic [7:0]  pl_addr = 8'h0;
    logic [31:0] pl_data = 32'h0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr[7:0]] <= mem_wdata;
        if (pl_en)            mem[pl_addr]       <= pl_data;
    end
    assign mem_rdata = mem[mem_addr[7:0]];

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .core_rd(core_rd), .core_wr(core_wr), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_rdata(core_rdata), .core_stall(core_stall),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    task clear_inputs;
        core_rd = 0; core_wr = 0; core_addr = '0; core_wdata = '0;
        ldr_req = 0; ldr_we = 0; ldr_addr = '0; ldr_wdata = '0;
    endtask

    task do_reset;
        clear_inputs();
        rst_n = 0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1;
    endtask

    task preload(input logic [7:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        pl_en = 1; pl_addr = a; pl_data = d;
        @(posedge clk); #1;
        pl_en = 0;
    endtask

    task test_reset;
        clear_inputs();
        core_rd = 1;
        #1 rst_n = 0;
        #2;
        total++; if (core_stall !== 1'b1) begin bad++; $display("FAIL rst_stall got=%b exp=1", core_stall); end
        total++; if ({mem_en, mem_we, ldr_ack} !== 3'b000) begin bad++; $display("FAIL rst_ctl got=%b exp=000", {mem_en, mem_we, ldr_ack}); end
        total++; if ({core_rdata, ldr_rdata} !== 64'h0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", {core_rdata, ldr_rdata}); end
        core_rd = 0;
        #1;
        total++; if (core_stall !== 1'b0) begin bad++; $display("FAIL rst_stall_idle got=%b exp=0", core_stall); end
        // Reset in the middle of a core write must clear latched address/data at once.
        @(posedge clk); #1;
        rst_n = 1;
        core_wr = 1; core_addr = 32'h77; core_wdata = 32'h1234;
        @(posedge clk); #1;
        total++; if (mem_en !== 1'b1) begin bad++; $display("FAIL rst_pre_access got=%b exp=1", mem_en); end
        rst_n = 0;
        #1;
        total++; if ({mem_en, mem_we} !== 2'b00) begin bad++; $display("FAIL rst_async_ctl got=%b exp=00", {mem_en, mem_we}); end
        total++; if ({mem_addr, mem_wdata} !== 64'h0) begin bad++; $display("FAIL rst_async_regs got=%h exp=0", {mem_addr, mem_wdata}); end
        total++; if (core_stall !== 1'b1) begin bad++; $display("FAIL rst_async_stall got=%b exp=1", core_stall); end
        do_reset();
    endtask

    task test_core_load;
        preload(8'h10, 32'hDEADBEEF);
        core_rd = 1; core_addr = 32'h10;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++; if (core_stall !== (k < 3)) begin bad++; $display("FAIL load_stall k=%0d got=%b exp=%b", k, core_stall, k < 3); end
            total++; if (mem_en !== (k == 1 || k == 2)) begin bad++; $display("FAIL load_en k=%0d got=%b", k, mem_en); end
            if (mem_en) begin
                total++; if ({mem_we, mem_addr} !== {1'b0, 32'h10}) begin bad++; $display("FAIL load_addr got=%h exp=10", mem_addr); end
            end
            if (k == 3) begin
                total++; if (core_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL load_data got=%h exp=deadbeef", core_rdata); end
            end
            @(posedge clk); #1;
        end
        core_rd = 0;
    endtask

    task test_ldr_then_core;
        ldr_req = 1; ldr_we = 1; ldr_addr = 32'h20; ldr_wdata = 32'h12345678;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++; if (ldr_ack !== (k == 3)) begin bad++; $display("FAIL ldr_ack k=%0d got=%b", k, ldr_ack); end
            total++; if (mem_we !== (k == 1 || k == 2)) begin bad++; $display("FAIL ldr_we k=%0d got=%b", k, mem_we); end
            @(posedge clk); #1;
        end
        ldr_req = 0; ldr_we = 0;
        total++; if (mem[8'h20] !== 32'h12345678) begin bad++; $display("FAIL ldr_mem got=%h exp=12345678", mem[8'h20]); end
        core_rd = 1; core_addr = 32'h20;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 3) begin
                total++; if ({core_stall, core_rdata} !== {1'b0, 32'h12345678}) begin bad++; $display("FAIL ldr_core_rd got=%b/%h exp=0/12345678", core_stall, core_rdata); end
            end
            @(posedge clk); #1;
        end
        core_rd = 0;
    endtask

    task test_starve;
        int rel, ack_at;
        do_reset();
        core_rd = 1; core_addr = 32'h20;
        ldr_req = 1; ldr_we = 0; ldr_addr = 32'h10;
        rel = 0; ack_at = -1;
        for (int k = 0; k < 30 && ack_at < 0; k++) begin
            @(negedge clk);
            if (!core_stall) rel++;
            if (ldr_ack) ack_at = k;
            @(posedge clk); #1;
        end
        clear_inputs();
        total++; if (ack_at !== 19) begin bad++; $display("FAIL starve_ack got=%0d exp=19", ack_at); end
        total++; if (rel !== 4) begin bad++; $display("FAIL starve_grants got=%0d exp=4", rel); end
        total++; if (ldr_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL starve_rdata got=%h exp=deadbeef", ldr_rdata); end
    endtask

    task test_same_cycle;
        do_reset();
        core_rd = 1; core_addr = 32'h20;
        ldr_req = 1; ldr_we = 0; ldr_addr = 32'h10;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            total++; if (ldr_ack !== (k == 7)) begin bad++; $display("FAIL same_ack k=%0d got=%b", k, ldr_ack); end
            if (k <= 3) begin
                total++; if (core_stall !== (k != 3)) begin bad++; $display("FAIL same_stall k=%0d got=%b", k, core_stall); end
            end
            if (k == 5) begin
                total++; if ({mem_en, mem_addr} !== {1'b1, 32'h10}) begin bad++; $display("FAIL same_ldr_addr got=%b/%h exp=1/10", mem_en, mem_addr); end
            end
            @(posedge clk); #1;
            if (k == 3) core_rd = 0;
            if (k == 7) ldr_req = 0;
        end
    endtask

    task test_reset_mid;
        do_reset();
        preload(8'h50, 32'h55AA55AA);
        ldr_req = 1; ldr_we = 0; ldr_addr = 32'h50;
        @(negedge clk); @(posedge clk); #1;
        @(negedge clk); @(posedge clk); #1;
        total++; if (mem_en !== 1'b1) begin bad++; $display("FAIL mid_pre got=%b exp=1", mem_en); end
        rst_n = 0; ldr_req = 0;
        #1;
        total++; if (mem_en !== 1'b0) begin bad++; $display("FAIL mid_en got=%b exp=0", mem_en); end
        @(posedge clk); #1;
        rst_n = 1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            total++; if ({ldr_ack, ldr_rdata} !== 33'h0) begin bad++; $display("FAIL mid_noack k=%0d got=%b/%h exp=0/0", k, ldr_ack, ldr_rdata); end
            @(posedge clk); #1;
        end
    endtask

    task test_ldr_drop;
        preload(8'h60, 32'h60606060);
        ldr_req = 1; ldr_we = 0; ldr_addr = 32'h60;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++; if (ldr_ack !== (k == 3)) begin bad++; $display("FAIL drop_ack k=%0d got=%b", k, ldr_ack); end
            if (k == 3) begin
                total++; if (ldr_rdata !== 32'h60606060) begin bad++; $display("FAIL drop_rdata got=%h exp=60606060", ldr_rdata); end
            end
            @(posedge clk); #1;
            if (k == 0) ldr_req = 0;
        end
    endtask

    task test_rw_both;
        int we_cnt;
        do_reset();
        core_rd = 1; core_wr = 1; core_addr = 32'h30; core_wdata = 32'hA5A5A5A5;
        we_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (mem_we) we_cnt++;
            @(posedge clk); #1;
        end
        clear_inputs();
        total++; if (we_cnt !== 2) begin bad++; $display("FAIL both_we got=%0d exp=2", we_cnt); end
        total++; if (mem[8'h30] !== 32'hA5A5A5A5) begin bad++; $display("FAIL both_mem got=%h exp=a5a5a5a5", mem[8'h30]); end
        core_rd = 1; core_addr = 32'h30;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 3) begin
                total++; if (core_rdata !== 32'hA5A5A5A5) begin bad++; $display("FAIL both_readback got=%h exp=a5a5a5a5", core_rdata); end
            end
            @(posedge clk); #1;
        end
        core_rd = 0;
    endtask

    // Random traffic. Each grant occupies the port for LAT+2 cycles; the owner
    // completes LAT+1 cycles after its grant. Writes read back their own data.
    task test_random;
        logic [31:0] ref_mem [0:15];
        logic [31:0] a, g_addr, g_wdata, g_val, core_val, ldr_val, exp_core, exp_ldr;
        logic        g_we, g_ldr, creq, exp_en;
        logic        core_pend, ldr_pend, ldr_granted, core_fin, ldr_fin;
        int          cyc, free_at, grant_at, core_done_at, ldr_done_at, starve;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = $urandom();
            preload(8'(i), ref_mem[i]);
        end
        cyc = 0; free_at = 0; grant_at = -100; core_done_at = -1; ldr_done_at = -1; starve = 0;
        exp_core = 0; exp_ldr = 0; core_val = 0; ldr_val = 0; g_we = 0; g_ldr = 0;
        g_addr = 0; g_wdata = 0; g_val = 0;
        core_pend = 0; ldr_pend = 0; ldr_granted = 0; core_fin = 0; ldr_fin = 0;
        for (int n = 0; n < 600; n++) begin
            if (core_fin) begin core_pend = 0; core_rd = 0; core_wr = 0; end
            if (ldr_fin)  begin ldr_pend = 0; ldr_granted = 0; ldr_req = 0; end
            if (!core_pend && $urandom_range(0, 99) < 50) begin
                core_pend = 1;
                case ($urandom_range(0, 2))
                    0:       begin core_rd = 1; core_wr = 0; end
                    1:       begin core_rd = 0; core_wr = 1; end
                    default: begin core_rd = 1; core_wr = 1; end
                endcase
                a = $urandom(); a[7:0] = 8'($urandom_range(0, 15));
                core_addr = a; core_wdata = $urandom();
            end
            if (!ldr_pend && $urandom_range(0, 99) < 30) begin
                ldr_pend = 1; ldr_req = 1; ldr_we = 1'($urandom_range(0, 1));
                a = $urandom(); a[7:0] = 8'($urandom_range(0, 15));
                ldr_addr = a; ldr_wdata = $urandom();
            end else if (ldr_pend && ldr_granted && $urandom_range(0, 99) < 30) begin
                ldr_req = 0;
            end
            @(negedge clk);
            creq = core_rd | core_wr;
            if (cyc >= free_at && (creq || ldr_req)) begin
                grant_at = cyc; free_at = cyc + LAT + 2;
                if (creq && !(ldr_req && starve == SMAX)) begin
                    g_ldr = 0; g_we = core_wr; g_addr = core_addr; g_wdata = core_wdata;
                    if (ldr_req && starve < SMAX) starve++;
                    core_done_at = cyc + LAT + 1;
                end else begin
                    g_ldr = 1; g_we = ldr_we; g_addr = ldr_addr; g_wdata = ldr_wdata;
                    starve = 0; ldr_granted = 1;
                    ldr_done_at = cyc + LAT + 1;
                end
                g_val = g_we ? g_wdata : ref_mem[g_addr[3:0]];
                if (g_we) ref_mem[g_addr[3:0]] = g_wdata;
                if (g_ldr) ldr_val = g_val; else core_val = g_val;
            end
            if (cyc == core_done_at) exp_core = core_val;
            if (cyc == ldr_done_at)  exp_ldr  = ldr_val;
            exp_en = (cyc > grant_at) && (cyc <= grant_at + LAT);
            total++; if (core_stall !== (creq && cyc != core_done_at)) begin bad++; $display("FAIL rnd_stall cyc=%0d got=%b", cyc, core_stall); end
            total++; if (ldr_ack !== (cyc == ldr_done_at)) begin bad++; $display("FAIL rnd_ack cyc=%0d got=%b", cyc, ldr_ack); end
            total++; if (mem_en !== exp_en) begin bad++; $display("FAIL rnd_en cyc=%0d got=%b exp=%b", cyc, mem_en, exp_en); end
            if (exp_en) begin
                total++; if ({mem_we, mem_addr} !== {g_we, g_addr}) begin bad++; $display("FAIL rnd_acc cyc=%0d got=%b/%h exp=%b/%h", cyc, mem_we, mem_addr, g_we, g_addr); end
                if (g_we) begin
                    total++; if (mem_wdata !== g_wdata) begin bad++; $display("FAIL rnd_wdata cyc=%0d got=%h exp=%h", cyc, mem_wdata, g_wdata); end
                end
            end
            total++; if (core_rdata !== exp_core) begin bad++; $display("FAIL rnd_core_rdata cyc=%0d got=%h exp=%h", cyc, core_rdata, exp_core); end
            total++; if (ldr_rdata !== exp_ldr) begin bad++; $display("FAIL rnd_ldr_rdata cyc=%0d got=%h exp=%h", cyc, ldr_rdata, exp_ldr); end
            core_fin = creq && !core_stall;
            ldr_fin  = ldr_ack;
            cyc++;
            @(posedge clk); #1;
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_core_load();
        test_ldr_then_core();
        test_starve();
        test_same_cycle();
        test_reset_mid();
        test_ldr_drop();
        test_rw_both();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width.
REQ-002 Parameter DATA_W, default 32, data width.
REQ-003 Parameter MEM_LAT, default 2, data-memory access latency in cycles (range 1..15).
REQ-004 Parameter STARVE_MAX, default 4, core-won grants tolerated while loader waits (range 1..15).
REQ-005 Ports (name  direction  width  meaning), one clock; reset is asynchronous and active-low:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- core_rd  in  1  MEM-stage load request, held while stalled
- core_wr  in  1  MEM-stage store request, held while stalled
- core_addr  in  ADDR_W  MEM-stage address
- core_wdata  in  DATA_W  MEM-stage store data
- core_rdata  out  DATA_W  load data, valid when core_stall falls
- core_stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
- ldr_req  in  1  loader/debug request, held until ldr_ack
- ldr_we  in  1  loader write (1) / read (0)
- ldr_addr  in  ADDR_W  loader address
- ldr_wdata  in  DATA_W  loader write data
- ldr_ack  out  1  one-cycle completion pulse
- ldr_rdata  out  DATA_W  loader read data, valid with ldr_ack
- mem_en  out  1  memory access active
- mem_we  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data

Function
REQ-006 The FSM SHALL have states IDLE, ACCESS and DONE, plus an owner register (CORE/LDR).
REQ-007 In IDLE, a core request (core_rd|core_wr) SHALL be granted unless ldr_req=1 and starve_cnt=STARVE_MAX; otherwise ldr_req SHALL be granted; with no request the FSM SHALL stay in IDLE.
REQ-008 A grant SHALL latch owner, addr, wdata and we (core: we=core_wr) into registers and move to ACCESS on the next edge.
REQ-009 In ACCESS, mem_en=1 and mem_we/mem_addr/mem_wdata SHALL be driven from the latched registers, held stable for exactly MEM_LAT cycles.
REQ-010 On the last ACCESS cycle, mem_rdata SHALL be captured into the owner's rdata register; the FSM SHALL then enter DONE.
REQ-011 DONE SHALL last one cycle: owner CORE -> core_stall=0; owner LDR -> ldr_ack=1. The FSM SHALL then return to IDLE.
REQ-012 core_stall SHALL be combinational: 1 whenever a core request is present, except in DONE with owner=CORE. Core latency from request to release SHALL be MEM_LAT+1 cycles when uncontended.
REQ-013 In IDLE and DONE, mem_en and mem_we SHALL be 0.
REQ-014 starve_cnt SHALL increment, saturating at STARVE_MAX, on each core grant made while ldr_req=1, and SHALL clear on a loader grant.
REQ-015 core_rd and core_wr both high SHALL be treated as a write.
REQ-016 ldr_req dropping before ldr_ack SHALL NOT abort the access; ldr_ack SHALL still pulse.
REQ-017 core_rdata/ldr_rdata SHALL hold their value until the next capture for the same owner.

Reset
REQ-018 rst_n low SHALL immediately force IDLE, owner CORE, starve_cnt 0, all latched registers 0, every output 0 except core_stall, which follows REQ-012 (1 if a core request is present).
REQ-019 Reset during ACCESS SHALL drop the access with no ldr_ack pulse and no rdata update.

Structure
REQ-020 A shared package/header SHALL hold the state encoding (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2), the owner encoding (CORE=1'b0, LDR=1'b1) and the default parameter values.
REQ-021 The latency counter SHALL be one sub-module, dmem_lat_counter: load MEM_LAT-1 and count down, asserting last at zero.

Verification (MEM_LAT=2, STARVE_MAX=4)
REQ-022 Core load to 0x10, memory holds 0xDEADBEEF -> core_stall high 3 cycles, core_rdata=0xDEADBEEF on the release cycle, mem_en high 2 cycles.
REQ-023 Loader write 0x20<-0x12345678, then core load to 0x20 -> ldr_ack at cycle 3, core_rdata=0x12345678.
REQ-024 Core requests back-to-back with ldr_req held -> loader granted after the 4th core grant; ldr_ack no later than cycle 4*4+3.
REQ-025 Core and loader requesting in the same IDLE cycle with starve_cnt<4 -> core granted first; loader granted next.
REQ-026 rst_n asserted on the 2nd ACCESS cycle of a loader read -> mem_en=0 immediately, no ldr_ack, ldr_rdata=0.
REQ-027 core_rd=core_wr=1, addr 0x30, wdata 0xA5A5A5A5 -> mem_we=1 for 2 cycles, and memory[0x30] reads 0xA5A5A5A5.
